// File: rtl/arc_pkg.sv
// Shared types and constants for the ARC MIPS pipeline control blocks.
package arc_pkg;

   typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

   localparam logic [1:0] ALUOP_BNE   = 2'b11;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/md_seq.sv
// Mul/div occupancy sequencer: tracks how long the HI/LO unit is busy and
// pulses done for the one cycle in which the result becomes valid.
module md_seq
   import arc_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic go,
   input  logic div,
   output logic busy,
   output logic done
);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   md_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] load_val;

   assign load_val = div ? DIV_LOAD : MUL_LOAD;

   // DONE accepts a new go directly so back-to-back ops skip the IDLE cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= MD_IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            MD_IDLE: begin
               if (go) begin
                  state_reg <= MD_BUSY;
                  cnt_reg   <= load_val;
               end
            end
            MD_BUSY: begin
               cnt_reg <= cnt_reg - CNT_ONE;
               if (cnt_reg == CNT_ONE) begin
                  state_reg <= MD_DONE;
               end
            end
            MD_DONE: begin
               if (go) begin
                  state_reg <= MD_BUSY;
                  cnt_reg   <= load_val;
               end else begin
                  state_reg <= MD_IDLE;
               end
            end
            default: begin
               state_reg <= MD_IDLE;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   assign busy = (state_reg == MD_BUSY);
   assign done = (state_reg == MD_DONE);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and mul/div
// issue/stall control for the 5-stage core.
module pipe_hazard_ctrl
   import arc_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   input  logic       i_id_md_start,
   input  logic       i_id_md_div,
   input  logic       i_id_uses_hilo,
   input  logic       i_ex_memread,
   input  logic [4:0] i_ex_rt,
   input  logic       i_ex_branch,
   input  logic [1:0] i_ex_aluop,
   input  logic       i_ex_zero,
   output logic       o_pc_en,
   output logic       o_ifid_en,
   output logic       o_ifid_flush,
   output logic       o_idex_flush,
   output logic       o_md_go,
   output logic       o_md_busy,
   output logic       o_md_done
);

   logic taken;
   logic lduse;
   logic mdhaz;

   assign taken = i_ex_branch & (i_ex_zero ^ (i_ex_aluop == ALUOP_BNE));
   assign lduse = i_ex_memread & (i_ex_rt != REG_ZERO) &
                  ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
   assign mdhaz = o_md_busy & (i_id_uses_hilo | i_id_md_start);

   // While reset is asserted the pipeline free-runs with nothing issued.
   always_comb begin
      o_pc_en      = 1'b1;
      o_ifid_en    = 1'b1;
      o_ifid_flush = 1'b0;
      o_idex_flush = 1'b0;
      o_md_go      = 1'b0;
      if (i_rst_n) begin
         if (taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
         end else if (lduse || mdhaz) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_flush = 1'b1;
         end else begin
            o_md_go = i_id_md_start;
         end
      end
   end

   md_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_seq (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .go    (o_md_go),
      .div   (i_id_md_div),
      .busy  (o_md_busy),
      .done  (o_md_done)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expected output vectors are queued
// per cycle and compared at the falling edge.
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_md_start;
   logic       id_md_div;
   logic       id_uses_hilo;
   logic       ex_memread;
   logic [4:0] ex_rt;
   logic       ex_branch;
   logic [1:0] ex_aluop;
   logic       ex_zero;
   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_flush;
   logic       md_go;
   logic       md_busy;
   logic       md_done;

   typedef struct {
      string      tag;
      logic [6:0] exp;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int        checks = 0;
   int        errors = 0;

   // {pc_en, ifid_en, ifid_flush, idex_flush, md_go, md_busy, md_done}
   localparam logic [6:0] E_RUN   = 7'b1100000;
   localparam logic [6:0] E_STALL = 7'b0001000;
   localparam logic [6:0] E_TAKEN = 7'b1111000;
   localparam logic [6:0] E_GO    = 7'b1100100;
   localparam logic [6:0] E_MDHAZ = 7'b0001010;
   localparam logic [6:0] E_BUSY  = 7'b1100010;
   localparam logic [6:0] E_DONE  = 7'b1100001;
   localparam logic [6:0] E_DNGO  = 7'b1100101;
   localparam logic [6:0] E_TKBSY = 7'b1111010;

   pipe_hazard_ctrl #(
      .MUL_CYCLES (4),
      .DIV_CYCLES (32),
      .CNT_W      (6)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .i_id_md_start  (id_md_start),
      .i_id_md_div    (id_md_div),
      .i_id_uses_hilo (id_uses_hilo),
      .i_ex_memread   (ex_memread),
      .i_ex_rt        (ex_rt),
      .i_ex_branch    (ex_branch),
      .i_ex_aluop     (ex_aluop),
      .i_ex_zero      (ex_zero),
      .o_pc_en        (pc_en),
      .o_ifid_en      (ifid_en),
      .o_ifid_flush   (ifid_flush),
      .o_idex_flush   (idex_flush),
      .o_md_go        (md_go),
      .o_md_busy      (md_busy),
      .o_md_done      (md_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      id_rs        = 5'd0;
      id_rt        = 5'd0;
      id_md_start  = 1'b0;
      id_md_div    = 1'b0;
      id_uses_hilo = 1'b0;
      ex_memread   = 1'b0;
      ex_rt        = 5'd0;
      ex_branch    = 1'b0;
      ex_aluop     = 2'b00;
      ex_zero      = 1'b0;
   endtask

   // Inputs are already driven; queue the expectation, check at negedge,
   // then advance to just after the next rising edge.
   task automatic step(input string tag, input logic [6:0] exp);
      sb_entry_t e;
      sb_entry_t got;
      logic [6:0] obs;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
      @(negedge clk);
      got = sb_q.pop_front();
      obs = {pc_en, ifid_en, ifid_flush, idex_flush, md_go, md_busy, md_done};
      checks++;
      assert (obs === got.exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", got.tag, obs, got.exp);
      end
      $display("%0t %s out=%b", $time, got.tag, obs);
      @(posedge clk);
      #1;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      step("reset", E_RUN);
      // Hazard inputs during reset must not disturb the defaults.
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_md_start = 1'b1;
      step("reset_gated", E_RUN);
      clear_inputs();
      rst_n = 1'b1;
      step("idle", E_RUN);

      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      step("lduse_rs", E_STALL);
      ex_memread = 1'b0;
      step("lduse_clear", E_RUN);
      ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd9;
      step("lduse_rt", E_STALL);
      clear_inputs();
      ex_memread = 1'b1; ex_rt = 5'd0; id_rt = 5'd0;
      step("load_r0", E_RUN);

      // bne taken while lduse and md_start are also present.
      ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_md_start = 1'b1;
      ex_branch = 1'b1; ex_aluop = 2'b11; ex_zero = 1'b0;
      step("bne_taken", E_TAKEN);
      clear_inputs();
      ex_branch = 1'b1; ex_aluop = 2'b11; ex_zero = 1'b1;
      step("bne_not_taken", E_RUN);
      ex_aluop = 2'b01;
      step("beq_taken", E_TAKEN);
      ex_zero = 1'b0;
      step("beq_not_taken", E_RUN);
      clear_inputs();

      // Multiply then HI/LO reader; a taken branch mid-op must not cancel it.
      id_md_start = 1'b1; id_md_div = 1'b0;
      step("mul_go", E_GO);
      clear_inputs();
      id_uses_hilo = 1'b1;
      step("mul_c1", E_MDHAZ);
      ex_branch = 1'b1; ex_aluop = 2'b01; ex_zero = 1'b1;
      step("mul_c2_taken", E_TKBSY);
      clear_inputs();
      id_uses_hilo = 1'b1;
      step("mul_c3", E_MDHAZ);
      step("mul_done", E_DONE);
      clear_inputs();
      step("mul_idle", E_RUN);

      // Divide with a second (multiply) start held in ID.
      id_md_start = 1'b1; id_md_div = 1'b1;
      step("div_go", E_GO);
      id_md_div = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         step($sformatf("div_stall_c%0d", i), E_MDHAZ);
      end
      step("div_done_go", E_DNGO);
      clear_inputs();
      for (int i = 33; i <= 35; i++) begin
         step($sformatf("b2b_busy_c%0d", i), E_BUSY);
      end
      step("b2b_done", E_DONE);
      step("b2b_idle", E_RUN);

      // Reset abandoned mid-divide.
      id_md_start = 1'b1; id_md_div = 1'b1;
      step("rdiv_go", E_GO);
      clear_inputs();
      for (int i = 1; i <= 9; i++) begin
         step($sformatf("rdiv_busy_c%0d", i), E_BUSY);
      end
      rst_n = 1'b0;
      ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_hilo = 1'b1;
      step("rdiv_rst_c10", E_BUSY);
      clear_inputs();
      rst_n = 1'b1;
      for (int i = 11; i <= 40; i++) begin
         step($sformatf("rdiv_after_c%0d", i), E_RUN);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
